// File: rtl/alu_issue_if.sv
// Instruction handshake, decoded ALU controls and ALU feedback between fetch/ALU and alu_issue_decoder.
// master = fetch/ALU side, slave = decoder side.
interface alu_issue_if;
  logic       in_valid;
  logic [8:0] in_inst;
  logic       in_ready;
  logic       issue_valid;
  logic       ri_type;
  logic [2:0] op;
  logic [1:0] op2;
  logic [1:0] rd;
  logic [1:0] rs;
  logic [7:0] imm8;
  logic       shift_dir;
  logic       word_sel;
  logic       carry_in;
  logic       overflow_in;
  logic       reg_write;
  logic [1:0] wr_addr;
  logic       branch_take;
  logic       illegal;
  logic       alu_carry;
  logic       alu_ovf;
  logic       alu_zero;
  logic       c_flag;
  logic       v_flag;

  modport master (
    output in_valid, in_inst, alu_carry, alu_ovf, alu_zero,
    input  in_ready, issue_valid, ri_type, op, op2, rd, rs, imm8, shift_dir, word_sel,
           carry_in, overflow_in, reg_write, wr_addr, branch_take, illegal, c_flag, v_flag
  );

  modport slave (
    input  in_valid, in_inst, alu_carry, alu_ovf, alu_zero,
    output in_ready, issue_valid, ri_type, op, op2, rd, rs, imm8, shift_dir, word_sel,
           carry_in, overflow_in, reg_write, wr_addr, branch_take, illegal, c_flag, v_flag
  );
endinterface

// File: rtl/alu_issue_decoder.sv
// ALU issue front end: decodes 9-bit instructions into registered ALU controls and owns C/V flags.
// ALU_ISSUE_WIDE_SHIFT_EN selects the two-beat 16-bit shift; undefined gives a single-beat shift.
module alu_issue_decoder (
  input  logic       clk,
  input  logic       reset,
  alu_issue_if.slave bus
);

`ifdef ALU_ISSUE_WIDE_SHIFT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, SHIFT_B = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1} state_t;
`endif

  state_t     state_r, next_state_s;
  logic       accept_s;
  logic       dec_itype_s, dec_shift_s, dec_add_s, dec_beqz_s;
  logic       dec_reg_write_s, dec_illegal_s, dec_hi_first_s;
  logic [2:0] dec_op_s;
  logic [1:0] dec_op2_s, dec_rd_s, dec_rs_s, dec_wr_addr_s;

  logic       in_ready_r, issue_valid_r, ri_type_r, shift_dir_r, word_sel_r;
  logic       reg_write_r, illegal_r, add_cin_r, is_add_r, is_beqz_r, is_shift_r;
  logic [2:0] op_r;
  logic [1:0] op2_r, rd_r, rs_r, wr_addr_r;
  logic [7:0] imm8_r;
  logic       c_flag_r, v_flag_r;

  assign accept_s = bus.in_valid & in_ready_r;

  // Instruction field decode for the word on the handshake
  always_comb begin
    dec_itype_s     = bus.in_inst[8];
    dec_op_s        = bus.in_inst[7:5];
    dec_op2_s       = bus.in_inst[7:6];
    dec_rs_s        = bus.in_inst[2:1];
    dec_rd_s        = dec_itype_s ? bus.in_inst[5:4] : bus.in_inst[4:3];
    dec_shift_s     = 1'b0;
    dec_add_s       = 1'b0;
    dec_beqz_s      = 1'b0;
    dec_reg_write_s = 1'b0;
    dec_illegal_s   = 1'b0;
    if (dec_itype_s) begin
      case (dec_op2_s)
        2'b00:   dec_beqz_s = 1'b1;
        2'b01:   dec_reg_write_s = 1'b1;
        default: dec_illegal_s = 1'b1;
      endcase
    end else begin
      case (dec_op_s)
        3'b001:  begin dec_add_s = 1'b1; dec_reg_write_s = 1'b1; end
        3'b101:  begin dec_shift_s = 1'b1; dec_reg_write_s = 1'b1; end
        3'b111:  dec_illegal_s = 1'b1;
        default: dec_reg_write_s = 1'b1;
      endcase
    end
`ifdef ALU_ISSUE_WIDE_SHIFT_EN
    // a right shift starts on the high word so its carry flows down into the low word
    dec_hi_first_s = dec_shift_s & bus.in_inst[0];
`else
    dec_hi_first_s = 1'b0;
`endif
    dec_wr_addr_s = dec_hi_first_s ? dec_rs_s : dec_rd_s;
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= next_state_s;
  end

  // FSM next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    if (accept_s) next_state_s = ISSUE; else next_state_s = IDLE;
`ifdef ALU_ISSUE_WIDE_SHIFT_EN
      ISSUE:   if (is_shift_r) next_state_s = SHIFT_B;
               else if (accept_s) next_state_s = ISSUE;
               else next_state_s = IDLE;
      SHIFT_B: if (accept_s) next_state_s = ISSUE; else next_state_s = IDLE;
`else
      ISSUE:   if (accept_s) next_state_s = ISSUE; else next_state_s = IDLE;
`endif
      default: next_state_s = IDLE;
    endcase
  end

  // Registered ALU control fields, loaded on accept and swapped for shift beat B
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready_r    <= 1'b0;
      issue_valid_r <= 1'b0;
      ri_type_r     <= 1'b0;
      op_r          <= 3'd0;
      op2_r         <= 2'd0;
      rd_r          <= 2'd0;
      rs_r          <= 2'd0;
      imm8_r        <= 8'd0;
      shift_dir_r   <= 1'b0;
      word_sel_r    <= 1'b0;
      wr_addr_r     <= 2'd0;
      reg_write_r   <= 1'b0;
      illegal_r     <= 1'b0;
      add_cin_r     <= 1'b0;
      is_add_r      <= 1'b0;
      is_beqz_r     <= 1'b0;
      is_shift_r    <= 1'b0;
    end else begin
`ifdef ALU_ISSUE_WIDE_SHIFT_EN
      in_ready_r <= ~(accept_s & dec_shift_s);
`else
      in_ready_r <= 1'b1;
`endif
      if (accept_s) begin
        issue_valid_r <= 1'b1;
        ri_type_r     <= dec_itype_s;
        op_r          <= dec_op_s;
        op2_r         <= dec_op2_s;
        rd_r          <= dec_rd_s;
        rs_r          <= dec_rs_s;
        imm8_r        <= {4'b0000, bus.in_inst[3:0]};
        shift_dir_r   <= bus.in_inst[0];
        word_sel_r    <= dec_hi_first_s;
        wr_addr_r     <= dec_wr_addr_s;
        reg_write_r   <= dec_reg_write_s;
        illegal_r     <= dec_illegal_s;
        add_cin_r     <= dec_add_s & bus.in_inst[0];
        is_add_r      <= dec_add_s;
        is_beqz_r     <= dec_beqz_s;
        is_shift_r    <= dec_shift_s;
`ifdef ALU_ISSUE_WIDE_SHIFT_EN
      end else if (next_state_s == SHIFT_B) begin
        issue_valid_r <= 1'b1;
        reg_write_r   <= 1'b1;
        illegal_r     <= 1'b0;
        word_sel_r    <= ~word_sel_r;
        wr_addr_r     <= word_sel_r ? rd_r : rs_r;
`endif
      end else begin
        issue_valid_r <= 1'b0;
        reg_write_r   <= 1'b0;
        illegal_r     <= 1'b0;
      end
    end
  end

  // Architectural flags, written on the edge that closes the owning beat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_flag_r <= 1'b0;
      v_flag_r <= 1'b0;
    end else begin
      if (issue_valid_r && is_add_r) v_flag_r <= bus.alu_ovf;
      if (issue_valid_r && is_shift_r && state_r == ISSUE) c_flag_r <= bus.alu_carry;
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.issue_valid = issue_valid_r;
  assign bus.ri_type     = ri_type_r;
  assign bus.op          = op_r;
  assign bus.op2         = op2_r;
  assign bus.rd          = rd_r;
  assign bus.rs          = rs_r;
  assign bus.imm8        = imm8_r;
  assign bus.shift_dir   = shift_dir_r;
  assign bus.word_sel    = word_sel_r;
  assign bus.carry_in    = c_flag_r;
  assign bus.overflow_in = add_cin_r & v_flag_r;
  assign bus.reg_write   = reg_write_r;
  assign bus.wr_addr     = wr_addr_r;
  assign bus.branch_take = issue_valid_r & is_beqz_r & bus.alu_zero;
  assign bus.illegal     = illegal_r;
  assign bus.c_flag      = c_flag_r;
  assign bus.v_flag      = v_flag_r;

endmodule

// File: tb/tb_alu_issue_decoder.sv
// Directed self-checking bench for alu_issue_decoder; adapts shift expectations to ALU_ISSUE_WIDE_SHIFT_EN.
module tb_alu_issue_decoder;
  logic clk = 1'b0;
  logic reset;
  int   chk_cnt = 0;
  int   pass_cnt = 0;

  alu_issue_if bus();

  alu_issue_decoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_inst   = 9'd0;
    bus.alu_carry = 1'b0;
    bus.alu_ovf   = 1'b0;
    bus.alu_zero  = 1'b0;
    tick();
    tick();
    check_val("rst_in_ready", 16'(bus.in_ready), 16'd0);
    check_val("rst_issue_valid", 16'(bus.issue_valid), 16'd0);
    check_val("rst_flags", 16'({bus.c_flag, bus.v_flag}), 16'd0);
    check_val("rst_fields", 16'({bus.reg_write, bus.wr_addr, bus.imm8, bus.illegal, bus.branch_take}), 16'd0);
    reset = 1'b0;
    tick();
    check_val("post_rst_in_ready", 16'(bus.in_ready), 16'd1);

    // ADD r1,r2 without carry-select, ALU reports overflow
    bus.in_valid = 1'b1;
    bus.in_inst  = {1'b0, 3'b001, 2'b01, 2'b10, 1'b0};
    tick();
    check_val("add0_issue", 16'({bus.issue_valid, bus.reg_write, bus.wr_addr}), 16'b1101);
    check_val("add0_ovf_in", 16'(bus.overflow_in), 16'd0);
    bus.alu_ovf = 1'b1;
    bus.in_inst = {1'b0, 3'b001, 2'b01, 2'b10, 1'b1};
    tick();
    check_val("add1_v_flag", 16'(bus.v_flag), 16'd1);
    check_val("add1_ovf_in", 16'(bus.overflow_in), 16'd1);
    bus.alu_ovf  = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    check_val("add1_v_cleared", 16'(bus.v_flag), 16'd0);
    check_val("add1_ovf_in_after", 16'(bus.overflow_in), 16'd0);
    check_val("idle_reg_write", 16'({bus.issue_valid, bus.reg_write}), 16'd0);

    // SHL {r3:r2}
    bus.in_valid = 1'b1;
    bus.in_inst  = {1'b0, 3'b101, 2'b10, 2'b11, 1'b0};
    tick();
    bus.in_valid  = 1'b0;
    bus.alu_carry = 1'b1;
    check_val("shl_a_word_sel", 16'(bus.word_sel), 16'd0);
    check_val("shl_a_wr_addr", 16'(bus.wr_addr), 16'd2);
    check_val("shl_a_carry_in", 16'(bus.carry_in), 16'd0);
`ifdef ALU_ISSUE_WIDE_SHIFT_EN
    check_val("shl_a_in_ready", 16'(bus.in_ready), 16'd0);
    tick();
    bus.alu_carry = 1'b0;
    check_val("shl_b_issue", 16'({bus.issue_valid, bus.reg_write}), 16'b11);
    check_val("shl_b_word_sel", 16'(bus.word_sel), 16'd1);
    check_val("shl_b_wr_addr", 16'(bus.wr_addr), 16'd3);
    check_val("shl_b_carry_in", 16'(bus.carry_in), 16'd1);
    check_val("shl_b_in_ready", 16'(bus.in_ready), 16'd1);
    tick();
    check_val("shl_done_c_flag", 16'(bus.c_flag), 16'd1);
    check_val("shl_done_issue", 16'(bus.issue_valid), 16'd0);
`else
    check_val("shl_in_ready", 16'(bus.in_ready), 16'd1);
    tick();
    bus.alu_carry = 1'b0;
    check_val("shl_done_c_flag", 16'(bus.c_flag), 16'd1);
    check_val("shl_done_carry_in", 16'(bus.carry_in), 16'd1);
    check_val("shl_done_issue", 16'(bus.issue_valid), 16'd0);
`endif

    // SHR {r3:r2} aborted by reset during its first beat
    bus.in_valid = 1'b1;
    bus.in_inst  = {1'b0, 3'b101, 2'b10, 2'b11, 1'b1};
    tick();
    bus.in_valid  = 1'b0;
    bus.alu_carry = 1'b1;
`ifdef ALU_ISSUE_WIDE_SHIFT_EN
    check_val("shr_a_sel_addr", 16'({bus.word_sel, bus.wr_addr}), 16'b111);
`else
    check_val("shr_a_sel_addr", 16'({bus.word_sel, bus.wr_addr}), 16'b010);
`endif
    reset = 1'b1;
    #1;
    check_val("shr_rst_issue", 16'({bus.issue_valid, bus.reg_write, bus.in_ready}), 16'd0);
    check_val("shr_rst_c_flag", 16'(bus.c_flag), 16'd0);
    tick();
    bus.alu_carry = 1'b0;
    reset = 1'b0;
    tick();
    check_val("shr_no_beat_b", 16'(bus.issue_valid), 16'd0);
    check_val("shr_c_flag", 16'(bus.c_flag), 16'd0);
    check_val("shr_in_ready", 16'(bus.in_ready), 16'd1);

    // BEQZ taken, then not taken
    bus.in_valid = 1'b1;
    bus.in_inst  = {1'b1, 2'b00, 2'b01, 4'b0000};
    tick();
    bus.in_valid = 1'b0;
    bus.alu_zero = 1'b1;
    #1;
    check_val("beqz_issue", 16'(bus.issue_valid), 16'd1);
    check_val("beqz_take", 16'(bus.branch_take), 16'd1);
    check_val("beqz_reg_write", 16'(bus.reg_write), 16'd0);
    tick();
    check_val("beqz_pulse_end", 16'(bus.branch_take), 16'd0);
    bus.alu_zero = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    #1;
    check_val("beqz_nt_issue", 16'(bus.issue_valid), 16'd1);
    check_val("beqz_nt_take", 16'(bus.branch_take), 16'd0);
    tick();

    // undefined R-type op followed by LI r2,#0xA, then undefined I-type op2
    bus.in_valid = 1'b1;
    bus.in_inst  = {1'b0, 3'b111, 2'b00, 2'b00, 1'b0};
    tick();
    bus.in_inst = {1'b1, 2'b01, 2'b10, 4'b1010};
    check_val("ill_pulse", 16'({bus.issue_valid, bus.illegal, bus.reg_write}), 16'b110);
    tick();
    bus.in_inst = {1'b1, 2'b10, 2'b00, 4'b0000};
    check_val("li_illegal", 16'(bus.illegal), 16'd0);
    check_val("li_write", 16'({bus.reg_write, bus.wr_addr}), 16'b110);
    check_val("li_imm8", 16'(bus.imm8), 16'h000A);
    check_val("li_ri_type", 16'(bus.ri_type), 16'd1);
    tick();
    bus.in_valid = 1'b0;
    check_val("itype_ill", 16'({bus.illegal, bus.reg_write}), 16'b10);
    tick();
    check_val("idle_clear", 16'({bus.issue_valid, bus.illegal, bus.reg_write}), 16'd0);
    check_val("idle_hold_ri", 16'(bus.ri_type), 16'd1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
